// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Memory operation selected from the controller flags.
  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_LB = 2'b01,
    OP_SW = 2'b10,
    OP_SB = 2'b11
  } op_e;

  // Little-endian byte lanes within a word.
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // The store flag has priority; sb_flag only matters for stores, lb_flag only for loads.
  function automatic op_e decode_op(input logic we, input logic sb_flag, input logic lb_flag);
    op_e op;
    if (we) begin
      op = sb_flag ? OP_SB : OP_SW;
    end else begin
      op = lb_flag ? OP_LB : OP_LW;
    end
    return op;
  endfunction

  // Word accesses are the only ones that can be misaligned.
  function automatic logic is_word_op(input op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Memory-stage request/response bundle between the controller and the responder.
interface dm_responder_if;
  logic        req;
  logic        we;
  logic        sb_flag;
  logic        lb_flag;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  modport master (
    output req, we, sb_flag, lb_flag, addr, wdata,
    input  rdata, ready, addr_err
  );

  modport slave (
    input  req, we, sb_flag, lb_flag, addr, wdata,
    output rdata, ready, addr_err
  );
endinterface

// File: rtl/dm_byte_lane.sv
// Byte-lane steering: merges a store byte into a word and extracts a sign-extended load byte.
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [7:0]  wbyte,
  input  logic [1:0]  lane,
  input  op_e         op,
  output logic [31:0] merged_word,
  output logic [31:0] load_word
);

  logic [7:0] sel_byte;

  // Select the addressed lane for loads and replace it for byte stores.
  always_comb begin
    sel_byte    = 8'h00;
    merged_word = old_word;
    case (lane)
      LANE0:   sel_byte = old_word[7:0];
      LANE1:   sel_byte = old_word[15:8];
      LANE2:   sel_byte = old_word[23:16];
      LANE3:   sel_byte = old_word[31:24];
      default: sel_byte = old_word[7:0];
    endcase
    if (op == OP_SB) begin
      case (lane)
        LANE0:   merged_word[7:0]   = wbyte;
        LANE1:   merged_word[15:8]  = wbyte;
        LANE2:   merged_word[23:16] = wbyte;
        LANE3:   merged_word[31:24] = wbyte;
        default: merged_word        = old_word;
      endcase
    end else begin
      merged_word = old_word;
    end
    load_word = {{24{sel_byte[7]}}, sel_byte};
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: latches one request, optionally waits, performs the
// access on an internal word array and returns a registered one-cycle response.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  dm_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  op_e             op_q, op_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            addr_err_q, addr_err_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] widx_s;
  logic [31:0]           mem_word_s;
  logic [31:0]           merged_s;
  logic [31:0]           load_byte_s;
  logic                  misalign_s;
  logic                  mem_we_s;
  logic [31:0]           mem_wdata_s;

  dm_byte_lane u_lane (
    .old_word    (mem_word_s),
    .wbyte       (wdata_q[7:0]),
    .lane        (addr_q[1:0]),
    .op          (op_q),
    .merged_word (merged_s),
    .load_word   (load_byte_s)
  );

  // Array access path driven from the latched request; upper address bits wrap away.
  always_comb begin
    widx_s      = addr_q[AW-1:2];
    mem_word_s  = mem[widx_s];
    misalign_s  = is_word_op(op_q) && (addr_q[1:0] != 2'b00);
    mem_we_s    = (state_q == ACCESS) && ((op_q == OP_SW) || (op_q == OP_SB)) && !misalign_s;
    mem_wdata_s = (op_q == OP_SB) ? merged_s : wdata_q;
  end

  // Next-state, latch and response computation for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    addr_err_d = addr_err_q;
    case (state_q)
      IDLE: begin
        addr_err_d = 1'b0;
        if (bus.req) begin
          addr_d  = bus.addr[AW-1:0];
          wdata_d = bus.wdata;
          op_d    = decode_op(bus.we, bus.sb_flag, bus.lb_flag);
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end else begin
          state_d = BUSY;
        end
      end
      ACCESS: begin
        state_d    = RESP;
        ready_d    = 1'b1;
        addr_err_d = misalign_s;
        case (op_q)
          OP_LW:   rdata_d = misalign_s ? 32'h0000_0000 : mem_word_s;
          OP_LB:   rdata_d = load_byte_s;
          OP_SW:   rdata_d = misalign_s ? 32'h0000_0000 : rdata_q;
          OP_SB:   rdata_d = rdata_q;
          default: rdata_d = rdata_q;
        endcase
      end
      RESP: begin
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      op_q       <= OP_LW;
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Word array write port; contents survive reset, and reset forces the FSM out of ACCESS.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[widx_s] <= mem_wdata_s;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with no wait states, one with three.
module tb_dm_responder;

  logic clk;
  logic rst0_n;
  logic rst3_n;
  int   n_vec;
  int   n_err;

  dm_responder_if if0 ();
  dm_responder_if if3 ();

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(if0));
  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic we, input logic sb,
                       input logic lb, input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      if0.req = r; if0.we = we; if0.sb_flag = sb; if0.lb_flag = lb; if0.addr = a; if0.wdata = wd;
    end else begin
      if3.req = r; if3.we = we; if3.sb_flag = sb; if3.lb_flag = lb; if3.addr = a; if3.wdata = wd;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if0.ready : if3.ready;
  endfunction

  // One access: lat counts negedges after the sampling edge until ready (-1 on timeout);
  // rdy_after is ready one cycle after the pulse.
  task automatic acc(input int sel, input logic we, input logic sb, input logic lb,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat,
                     output logic rdy_after);
    int  cyc;
    logic got;
    @(negedge clk);
    drive(sel, 1'b1, we, sb, lb, a, wd);
    @(posedge clk);
    cyc = 0; got = 1'b0; rd = 32'hxxxx_xxxx; er = 1'bx;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (rdy(sel)) begin
        got = 1'b1;
        rd  = (sel == 0) ? if0.rdata : if3.rdata;
        er  = (sel == 0) ? if0.addr_err : if3.addr_err;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = got ? cyc : -1;
    @(negedge clk);
    rdy_after = rdy(sel);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        ra;
    int          cyc;
    n_vec = 0; n_err = 0;
    rst0_n = 1'b0; rst3_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_rdata0", if0.rdata, 32'h0);
    check("rst_ready0", {31'd0, if0.ready}, 32'h0);
    check("rst_err0", {31'd0, if0.addr_err}, 32'h0);
    check("rst_rdata3", if3.rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // No-wait instance: store then load, latency 2.
    acc(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, ra);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'd0, er}, 32'h0);
    acc(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, ra);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'h0);
    check("lw_lat", lat, 32'd2);
    check("lw_pulse", {31'd0, ra}, 32'h0);

    // Byte store into lane 2.
    acc(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, rd, er, lat, ra);
    acc(0, 1'b1, 1'b1, 1'b0, 32'h22, 32'h000000AA, rd, er, lat, ra);
    acc(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, ra);
    check("sb_merge", rd, 32'h11AA3344);

    // Sign-extended byte loads.
    acc(0, 1'b0, 1'b0, 1'b1, 32'h22, 32'h0, rd, er, lat, ra);
    check("lb_neg", rd, 32'hFFFFFFAA);
    acc(0, 1'b0, 1'b0, 1'b1, 32'h23, 32'h0, rd, er, lat, ra);
    check("lb_pos", rd, 32'h00000011);
    acc(0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, rd, er, lat, ra);
    check("lb_lane0", rd, 32'h00000044);

    // Misaligned word accesses.
    acc(0, 1'b0, 1'b0, 1'b0, 32'h21, 32'h0, rd, er, lat, ra);
    check("mis_lw_err", {31'd0, er}, 32'h1);
    check("mis_lw_data", rd, 32'h0);
    acc(0, 1'b1, 1'b0, 1'b0, 32'h22, 32'hFFFFFFFF, rd, er, lat, ra);
    check("mis_sw_err", {31'd0, er}, 32'h1);
    acc(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, ra);
    check("mis_sw_nowrite", rd, 32'h11AA3344);
    check("mis_err_clear", {31'd0, er}, 32'h0);

    // Ignored flags, rdata hold on sb, address wrap.
    acc(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, rd, er, lat, ra);
    acc(0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat, ra);
    check("flag_ignore", rd, 32'h0BADF00D);
    acc(0, 1'b1, 1'b1, 1'b0, 32'h43, 32'h12345680, rd, er, lat, ra);
    check("sb_rdata_hold", rd, 32'h0BADF00D);
    acc(0, 1'b0, 1'b0, 1'b1, 32'h43, 32'h0, rd, er, lat, ra);
    check("lb_lane3", rd, 32'hFFFFFF80);
    acc(0, 1'b0, 1'b0, 1'b0, 32'h1020, 32'h0, rd, er, lat, ra);
    check("addr_wrap", rd, 32'h11AA3344);

    // Three-wait instance: latency 5, pulse width 1.
    acc(3, 1'b1, 1'b0, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat, ra);
    check("w3_sw_lat", lat, 32'd5);
    acc(3, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, ra);
    check("w3_lw_data", rd, 32'hCAFEF00D);
    check("w3_lw_lat", lat, 32'd5);
    check("w3_pulse", {31'd0, ra}, 32'h0);

    // req held through RESP: next response 3+3 cycles after the previous.
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    cyc = 0;
    while (cyc < 40 && !if3.ready) begin
      @(negedge clk);
      cyc++;
    end
    check("held_first", {31'd0, if3.ready}, 32'h1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (cyc < 40 && !if3.ready);
    drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("held_gap", cyc, 32'd6);
    repeat (2) @(negedge clk);

    // Reset during BUSY aborts a pending store.
    acc(3, 1'b1, 1'b0, 1'b0, 32'h30, 32'h12345678, rd, er, lat, ra);
    acc(3, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, ra);
    check("pre_rst_data", rd, 32'h12345678);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h00000055);
    @(posedge clk);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst3_n = 1'b0;
    #1;
    check("midrst_rdata", if3.rdata, 32'h0);
    check("midrst_ready", {31'd0, if3.ready}, 32'h0);
    check("midrst_err", {31'd0, if3.addr_err}, 32'h0);
    repeat (6) @(negedge clk);
    check("midrst_noready", {31'd0, if3.ready}, 32'h0);
    rst3_n = 1'b1;
    acc(3, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, ra);
    check("midrst_nowrite", rd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
